// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic GEMM tile engine.
// Holds the tile FSM encoding, flush-length arithmetic and operand extension.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        SWAP  = 2'd3
    } sa_state_e;

    // Widest operand the extension helper handles.
    localparam int SA_EXT_W = 32;

    // Cycles for the last beat to reach the far corner PE of the grid.
    function automatic int sa_flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    // Extend a width-bit operand to a signed value, sign- or zero-filled by sgn.
    function automatic logic signed [SA_EXT_W:0] sa_mac_ext(input logic [SA_EXT_W-1:0] op,
                                                            input int width,
                                                            input logic sgn);
        logic signed [SA_EXT_W:0] r;
        logic fill;
        fill = sgn & op[width-1];
        for (int i = 0; i < SA_EXT_W; i++) begin
            r[i] = (i < width) ? op[i] : fill;
        end
        r[SA_EXT_W] = fill;
        return r;
    endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// One processing element: registered operand pass-through (right/down)
// and a wrapping accumulator cleared when the tile is swapped out.
module sa_mac_pe
    import sa_pkg::*;
#(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sgn,
    input  logic              clr,
    input  logic [IWIDTH-1:0] a_in,
    input  logic              a_vin,
    input  logic [IWIDTH-1:0] b_in,
    input  logic              b_vin,
    output logic [IWIDTH-1:0] a_out,
    output logic              a_vout,
    output logic [IWIDTH-1:0] b_out,
    output logic              b_vout,
    output logic [OWIDTH-1:0] acc
);

    logic signed [OWIDTH-1:0] a_x;
    logic signed [OWIDTH-1:0] b_x;
    logic signed [OWIDTH-1:0] prod;

    // Product is exact modulo 2^OWIDTH, which is all the wrapping accumulator needs.
    always_comb begin
        a_x  = OWIDTH'(sa_mac_ext(SA_EXT_W'(a_in), IWIDTH, sgn));
        b_x  = OWIDTH'(sa_mac_ext(SA_EXT_W'(b_in), IWIDTH, sgn));
        prod = a_x * b_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out  <= '0;
            a_vout <= 1'b0;
            b_out  <= '0;
            b_vout <= 1'b0;
            acc    <= '0;
        end else begin
            a_out  <= a_in;
            a_vout <= a_vin;
            b_out  <= b_in;
            b_vout <= b_vin;
            if (clr) begin
                acc <= '0;
            end else if (a_vin && b_vin) begin
                acc <= acc + prod;
            end
        end
    end

endmodule

// File: rtl/sa_tile_engine.sv
// Output-stationary ROWS x COLS systolic tile engine with input skew,
// tile-sequencing FSM and a double-buffered row-by-row output drain.
module sa_tile_engine
    import sa_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic              sgn,
    input  logic [IWIDTH-1:0] ifm [ROWS],
    input  logic [IWIDTH-1:0] wght [COLS],
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [OWIDTH-1:0] ofm [COLS],
    output logic              busy
);

    localparam int FLUSH_LEN = sa_flush_len(ROWS, COLS);
    localparam int CW = $clog2(FLUSH_LEN + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    sa_state_e         state, state_nxt;
    logic [CW-1:0]     fcnt, fcnt_nxt;
    logic              sgn_q;
    logic              beat, swap_ok, swap_fire, last_hs;
    logic              occ;
    logic [RW-1:0]     rptr;

    logic [IWIDTH-1:0] a_edge [ROWS];
    logic              av_edge [ROWS];
    logic [IWIDTH-1:0] b_edge [COLS];
    logic              bv_edge [COLS];
    logic [IWIDTH-1:0] a_o [ROWS][COLS];
    logic              av_o [ROWS][COLS];
    logic [IWIDTH-1:0] b_o [ROWS][COLS];
    logic              bv_o [ROWS][COLS];
    logic [OWIDTH-1:0] acc [ROWS][COLS];
    logic [OWIDTH-1:0] obuf [ROWS][COLS];

    assign beat      = in_valid & in_ready;
    assign last_hs   = occ & out_ready & (rptr == LAST_ROW);
    // A last-row handshake in the same cycle frees the buffer for the swap.
    assign swap_ok   = ~occ | last_hs;
    assign swap_fire = (state == SWAP) & swap_ok;

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                fcnt_nxt = '0;
                if (in_valid) state_nxt = in_last ? FLUSH : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (fcnt == CW'(FLUSH_LEN - 1)) state_nxt = SWAP;
                else fcnt_nxt = fcnt + 1'b1;
            end
            SWAP: begin
                if (swap_ok) begin
                    state_nxt = IDLE;
                    fcnt_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fcnt  <= '0;
            sgn_q <= 1'b0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (state == IDLE && in_valid) sgn_q <= sgn;
        end
    end

    // Row r gets r+1 register stages so PE(r,c) sees beat k at t_k+r+c.
    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        logic [IWIDTH-1:0] d [r+1];
        logic              v [r+1];
        logic              tail_unused;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) begin
                    d[i] <= '0;
                    v[i] <= 1'b0;
                end
            end else begin
                d[0] <= ifm[r];
                v[0] <= beat;
                for (int i = 1; i <= r; i++) begin
                    d[i] <= d[i-1];
                    v[i] <= v[i-1];
                end
            end
        end
        assign a_edge[r]   = d[r];
        assign av_edge[r]  = v[r];
        assign tail_unused = ^{a_o[r][COLS-1], av_o[r][COLS-1]};
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        logic [IWIDTH-1:0] d [c+1];
        logic              v [c+1];
        logic              tail_unused;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= c; i++) begin
                    d[i] <= '0;
                    v[i] <= 1'b0;
                end
            end else begin
                d[0] <= wght[c];
                v[0] <= beat;
                for (int i = 1; i <= c; i++) begin
                    d[i] <= d[i-1];
                    v[i] <= v[i-1];
                end
            end
        end
        assign b_edge[c]   = d[c];
        assign bv_edge[c]  = v[c];
        assign tail_unused = ^{b_o[ROWS-1][c], bv_o[ROWS-1][c]};
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [IWIDTH-1:0] a_i, b_i;
            logic              av_i, bv_i;
            if (c == 0) begin : g_a_edge
                assign a_i  = a_edge[r];
                assign av_i = av_edge[r];
            end else begin : g_a_pass
                assign a_i  = a_o[r][c-1];
                assign av_i = av_o[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_i  = b_edge[c];
                assign bv_i = bv_edge[c];
            end else begin : g_b_pass
                assign b_i  = b_o[r-1][c];
                assign bv_i = bv_o[r-1][c];
            end
            sa_mac_pe #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH)) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .sgn    (sgn_q),
                .clr    (swap_fire),
                .a_in   (a_i),
                .a_vin  (av_i),
                .b_in   (b_i),
                .b_vin  (bv_i),
                .a_out  (a_o[r][c]),
                .a_vout (av_o[r][c]),
                .b_out  (b_o[r][c]),
                .b_vout (bv_o[r][c]),
                .acc    (acc[r][c])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 1'b0;
            rptr <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    obuf[r][c] <= '0;
        end else if (swap_fire) begin
            occ  <= 1'b1;
            rptr <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    obuf[r][c] <= acc[r][c];
        end else if (occ && out_ready) begin
            if (rptr == LAST_ROW) begin
                occ  <= 1'b0;
                rptr <= '0;
            end else begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) ofm[c] = obuf[rptr][c];
    end

    assign out_valid = occ;
    assign out_last  = occ & (rptr == LAST_ROW);
    assign busy      = (state != IDLE) | occ;

endmodule
